// File: rtl/motion_pkg.sv
// Shared types and widths for the motion datapath.
package motion_pkg;
  localparam int X_W   = 8;
  localparam int DIV_W = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/motion_datapath_if.sv
// Controller <-> motion datapath bus; the datapath uses the slave modport.
interface motion_datapath_if;
  import motion_pkg::*;

  logic             start;
  logic             move;
  logic [X_W-1:0]   x_init;
  logic [X_W-1:0]   x_limit;
  logic             dir;
  logic [DIV_W-1:0] rate;
  logic [X_W-1:0]   x;
  logic             stop;
  logic             busy;

  modport master (
    output start, move, x_init, x_limit, dir, rate,
    input  x, stop, busy
  );

  modport slave (
    input  start, move, x_init, x_limit, dir, rate,
    output x, stop, busy
  );
endinterface

// File: rtl/motion_datapath_rate_divider.sv
// Down-counting step divider: tick while the count is zero, reload on a ticking enable.
module rate_divider
  import motion_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= rate;
    else if (enable)
      cnt <= (cnt == '0) ? rate : cnt - 1'b1;
  end

  assign tick = (cnt == '0);
endmodule

// File: rtl/motion_datapath.sv
// Position FSM: loads on start, steps x at the divided rate while moving, pulses stop at the limit.
module motion_datapath
  import motion_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  motion_datapath_if.slave   bus
);
  state_t         state, state_nxt;
  logic [X_W-1:0] x_q, x_nxt;
  logic           stop_q, stop_nxt;
  logic           busy_q;
  logic           div_load, div_en, div_tick;

  rate_divider u_div (
    .clk    (clk),
    .reset  (reset),
    .load   (div_load),
    .enable (div_en),
    .rate   (bus.rate),
    .tick   (div_tick)
  );

  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    stop_nxt  = 1'b0;
    div_load  = 1'b0;
    div_en    = 1'b0;
    if (bus.start) begin
      state_nxt = S_RUN;
      x_nxt     = bus.x_init;
      div_load  = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (bus.move) begin
            // Limit check comes before stepping so x never overshoots the target.
            if (x_q == bus.x_limit) begin
              stop_nxt  = 1'b1;
              state_nxt = S_DONE;
            end else begin
              div_en = 1'b1;
              if (div_tick)
                x_nxt = bus.dir ? x_q + 1'b1 : x_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      x_q    <= '0;
      stop_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      x_q    <= x_nxt;
      stop_q <= stop_nxt;
      busy_q <= (state_nxt == S_RUN);
    end
  end

  assign bus.x    = x_q;
  assign bus.stop = stop_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_motion_datapath.sv
// Directed vector table plus hand-written reset sequences for motion_datapath.
module tb_motion_datapath;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  motion_datapath_if bus ();

  motion_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        start;
    logic        move;
    logic [7:0]  x_init;
    logic [7:0]  x_limit;
    logic        dir;
    logic [19:0] rate;
    logic [7:0]  exp_x;
    logic        exp_stop;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic st, input logic mv, input logic [7:0] xi,
                     input logic [7:0] xl, input logic d, input logic [19:0] r,
                     input logic [7:0] ex, input logic es, input logic eb);
    vec_t v;
    v.name = nm; v.start = st; v.move = mv; v.x_init = xi; v.x_limit = xl;
    v.dir = d; v.rate = r; v.exp_x = ex; v.exp_stop = es; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic mv, input logic [7:0] xi,
                       input logic [7:0] xl, input logic d, input logic [19:0] r);
    bus.start = st; bus.move = mv; bus.x_init = xi; bus.x_limit = xl;
    bus.dir = d; bus.rate = r;
  endtask

  task automatic check(input string nm, input logic [7:0] ex, input logic es, input logic eb);
    n_tests++;
    if (bus.x !== ex || bus.stop !== es || bus.busy !== eb) begin
      n_fail++;
      $display("FAIL %s: got x=%0d stop=%b busy=%b, want x=%0d stop=%b busy=%b",
               nm, bus.x, bus.stop, bus.busy, ex, es, eb);
    end
  endtask

  task automatic step_check(input string nm, input logic st, input logic mv, input logic [7:0] xi,
                            input logic [7:0] xl, input logic d, input logic [19:0] r,
                            input logic [7:0] ex, input logic es, input logic eb);
    @(negedge clk);
    drive(st, mv, xi, xl, d, r);
    @(posedge clk);
    #1;
    check(nm, ex, es, eb);
  endtask

  initial begin
    // count up, rate 0
    add("up_arm",   1, 0, 10, 13, 1, 0, 10, 0, 1);
    add("up_s1",    0, 1, 10, 13, 1, 0, 11, 0, 1);
    add("up_s2",    0, 1, 10, 13, 1, 0, 12, 0, 1);
    add("up_s3",    0, 1, 10, 13, 1, 0, 13, 0, 1);
    add("up_stop",  0, 1, 10, 13, 1, 0, 13, 1, 0);
    add("up_done",  0, 1, 10, 13, 1, 0, 13, 0, 0);
    // rate 3: step every 4 move cycles, stop on the 9th
    add("r3_arm",   1, 0, 0, 2, 1, 3, 0, 0, 1);
    add("r3_m1",    0, 1, 0, 2, 1, 3, 0, 0, 1);
    add("r3_m2",    0, 1, 0, 2, 1, 3, 0, 0, 1);
    add("r3_m3",    0, 1, 0, 2, 1, 3, 0, 0, 1);
    add("r3_m4",    0, 1, 0, 2, 1, 3, 1, 0, 1);
    add("r3_m5",    0, 1, 0, 2, 1, 3, 1, 0, 1);
    add("r3_m6",    0, 1, 0, 2, 1, 3, 1, 0, 1);
    add("r3_m7",    0, 1, 0, 2, 1, 3, 1, 0, 1);
    add("r3_m8",    0, 1, 0, 2, 1, 3, 2, 0, 1);
    add("r3_m9",    0, 1, 0, 2, 1, 3, 2, 1, 0);
    // wrap upward
    add("wu_arm",   1, 0, 254, 1, 1, 0, 254, 0, 1);
    add("wu_s1",    0, 1, 254, 1, 1, 0, 255, 0, 1);
    add("wu_s2",    0, 1, 254, 1, 1, 0, 0, 0, 1);
    add("wu_s3",    0, 1, 254, 1, 1, 0, 1, 0, 1);
    add("wu_stop",  0, 1, 254, 1, 1, 0, 1, 1, 0);
    // wrap downward
    add("wd_arm",   1, 0, 1, 254, 0, 0, 1, 0, 1);
    add("wd_s1",    0, 1, 1, 254, 0, 0, 0, 0, 1);
    add("wd_s2",    0, 1, 1, 254, 0, 0, 255, 0, 1);
    add("wd_s3",    0, 1, 1, 254, 0, 0, 254, 0, 1);
    add("wd_stop",  0, 1, 1, 254, 0, 0, 254, 1, 0);
    // already at limit
    add("eq_arm",   1, 0, 50, 50, 1, 0, 50, 0, 1);
    add("eq_stop",  0, 1, 50, 50, 1, 0, 50, 1, 0);
    add("eq_done",  0, 1, 50, 50, 1, 0, 50, 0, 0);
    // pause: divider and x frozen while move=0
    add("pz_arm",   1, 0, 5, 9, 1, 1, 5, 0, 1);
    add("pz_m1",    0, 1, 5, 9, 1, 1, 5, 0, 1);
    add("pz_p1",    0, 0, 5, 9, 1, 1, 5, 0, 1);
    add("pz_p2",    0, 0, 5, 9, 1, 1, 5, 0, 1);
    add("pz_p3",    0, 0, 5, 9, 1, 1, 5, 0, 1);
    add("pz_p4",    0, 0, 5, 9, 1, 1, 5, 0, 1);
    add("pz_p5",    0, 0, 5, 9, 1, 1, 5, 0, 1);
    add("pz_m2",    0, 1, 5, 9, 1, 1, 6, 0, 1);
    add("pz_lim",   0, 0, 5, 6, 1, 1, 6, 0, 1);
    // start beats move: x and divider reload mid-run
    add("rl_arm",   1, 0, 100, 110, 1, 2, 100, 0, 1);
    add("rl_m1",    0, 1, 100, 110, 1, 2, 100, 0, 1);
    add("rl_m2",    0, 1, 100, 110, 1, 2, 100, 0, 1);
    add("rl_both",  1, 1, 120, 130, 1, 2, 120, 0, 1);
    add("rl_m3",    0, 1, 120, 130, 1, 2, 120, 0, 1);
    add("rl_m4",    0, 1, 120, 130, 1, 2, 120, 0, 1);
    add("rl_m5",    0, 1, 120, 130, 1, 2, 121, 0, 1);
    // restart from DONE
    add("rs_stop",  0, 1, 120, 121, 1, 0, 121, 1, 0);
    add("rs_arm",   1, 1, 7, 9, 1, 0, 7, 0, 1);

    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    check("reset_state", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i])
      step_check(vecs[i].name, vecs[i].start, vecs[i].move, vecs[i].x_init,
                 vecs[i].x_limit, vecs[i].dir, vecs[i].rate,
                 vecs[i].exp_x, vecs[i].exp_stop, vecs[i].exp_busy);

    // reset between edges in the middle of a run
    step_check("mr_arm", 1, 0, 40, 60, 1, 0, 40, 0, 1);
    step_check("mr_s1",  0, 1, 40, 60, 1, 0, 41, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_async", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step_check("mr_ign1", 0, 1, 40, 60, 1, 0, 0, 0, 0);
    step_check("mr_ign2", 0, 1, 40, 60, 1, 0, 0, 0, 0);
    step_check("mr_rearm", 1, 0, 40, 60, 1, 0, 40, 0, 1);

    // reset during the stop pulse clears it immediately
    step_check("sp_arm",  1, 0, 3, 3, 1, 0, 3, 0, 1);
    step_check("sp_stop", 0, 1, 3, 3, 1, 0, 3, 1, 0);
    reset = 1'b1;
    #1;
    check("sp_async", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step_check("sp_after", 0, 1, 3, 3, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/motion_datapath.md
MOTION_DATAPATH -- requirements
Module: motion_datapath

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: level from the controller; while high, the block loads the initial position and arms.
REQ-004 The block SHALL have the port move, input, 1 bit: level from the controller; while high and armed, the block advances the position.
REQ-005 The block SHALL have the port x_init, input, 8 bits: start position, sampled while start=1.
REQ-006 The block SHALL have the port x_limit, input, 8 bits: target position, sampled every cycle.
REQ-007 The block SHALL have the port dir, input, 1 bit: 1 means increment x, 0 means decrement x; sampled at each step.
REQ-008 The block SHALL have the port rate, input, 20 bits: divider reload; a step occurs every rate+1 move cycles.
REQ-009 The block SHALL have the port x, output, 8 bits: current position, registered.
REQ-010 The block SHALL have the port stop, output, 1 bit: registered one-cycle pulse meaning target reached; it goes to the controller's stop input.
REQ-011 The block SHALL have the port busy, output, 1 bit: registered, high while in S_RUN.

Function
REQ-012 The block SHALL implement FSM states S_IDLE, S_RUN and S_DONE.
REQ-013 In any state, start=1 SHALL on the next edge load x<=x_init and div_cnt<=rate, enter S_RUN, and force stop=0; start SHALL take priority over move in the same cycle.
REQ-014 In S_IDLE and S_DONE, move SHALL be ignored and x SHALL hold.
REQ-015 In S_RUN with start=0 and move=1, if x==x_limit, the block SHALL on the next edge set stop=1 for exactly one cycle, enter S_DONE, and not step.
REQ-016 In S_RUN with start=0, move=1, x!=x_limit and div_cnt==0, the block SHALL on the next edge step x by +1 (dir=1) or -1 (dir=0) and reload div_cnt<=rate.
REQ-017 In S_RUN with start=0, move=1, x!=x_limit and div_cnt!=0, the block SHALL decrement div_cnt and hold x.
REQ-018 In S_RUN with move=0, div_cnt and x SHALL hold (pause), and no stop SHALL be issued.
REQ-019 x arithmetic SHALL be modulo 256 (255+1=0, 0-1=255); there SHALL be no saturation, so the limit is reached after wrap.
REQ-020 With rate=0, the block SHALL step on every move cycle.
REQ-021 Stop latency: stop SHALL assert on the edge after the first move cycle in which x==x_limit; the minimum total from arming with x_init==x_limit SHALL be 1 move cycle.
REQ-022 stop SHALL be high only in the first cycle of S_DONE, and SHALL never be high in two consecutive cycles.
REQ-023 busy SHALL equal (state==S_RUN), registered.

Reset
REQ-024 reset=1 SHALL asynchronously force state=S_IDLE, x=0, div_cnt=0, stop=0 and busy=0, including mid-run; operation SHALL resume only via start after reset is released.

Structure
REQ-025 A shared package motion_pkg SHALL hold the state enum, X_W=8 and DIV_W=20.
REQ-026 The divider SHALL be one sub-module, rate_divider, with load, enable and rate inputs and a tick output.
REQ-027 The FSM and the position register SHALL be located in motion_datapath.

Verification
REQ-028 The bench SHALL cover: x_init=10, x_limit=13, dir=1, rate=0, start for 1 cycle then move held -> x=11,12,13 on successive edges, stop pulses once, busy falls.
REQ-029 The bench SHALL cover: rate=3, x_init=0, x_limit=2, dir=1 -> x steps every 4 move cycles, and stop asserts 9 move cycles after arming.
REQ-030 The bench SHALL cover: x_init=254, x_limit=1, dir=1, rate=0 -> x=255,0,1, then stop (wrap).
REQ-031 The bench SHALL cover: x_init=x_limit=50 with move -> stop on the first move edge, and x stays 50.
REQ-032 The bench SHALL cover: mid-run move dropped for 5 cycles -> x and the divider frozen, and no stop; start and move high together -> reload wins.
REQ-033 The bench SHALL cover: reset asserted mid-run, between clock edges -> x=0, busy=0 and stop=0 immediately; move after release is ignored until start.
